// File: rtl/ccip_shim_buffer.sv
// CCI-P shim: Rx fields delayed by a configurable pipeline, Tx c0/c1 buffered in FIFOs
// that drain only while the platform is not almost-full, and c2 registered once.
module ccip_shim_buffer #(
    parameter int unsigned RX_STAGES           = 1,
    parameter int unsigned TX_DEPTH            = 8,
    parameter int unsigned AF_SLACK            = 4,
    parameter int unsigned CCIP_C0RX_HDR_WIDTH = 28,
    parameter int unsigned CCIP_C1RX_HDR_WIDTH = 28,
    parameter int unsigned CCIP_CLDATA_WIDTH   = 512,
    parameter int unsigned CCIP_C0TX_HDR_WIDTH = 74,
    parameter int unsigned CCIP_C1TX_HDR_WIDTH = 80,
    parameter int unsigned CCIP_C2TX_HDR_WIDTH = 9,
    parameter int unsigned CCIP_MMIODATA_WIDTH = 64
) (
    input  logic                           pClk,
    input  logic                           pck_cp2af_softReset_n,
    input  logic                           c0TxAlmFull,
    input  logic                           c1TxAlmFull,
    input  logic [CCIP_C0RX_HDR_WIDTH-1:0] c0Rx_hdr,
    input  logic [CCIP_CLDATA_WIDTH-1:0]   c0Rx_data,
    input  logic                           c0Rx_rspValid,
    input  logic                           c0Rx_mmioRdValid,
    input  logic                           c0Rx_mmioWrValid,
    input  logic [CCIP_C1RX_HDR_WIDTH-1:0] c1Rx_hdr,
    input  logic                           c1Rx_rspValid,
    output logic [CCIP_C0RX_HDR_WIDTH-1:0] afu_c0Rx_hdr,
    output logic [CCIP_CLDATA_WIDTH-1:0]   afu_c0Rx_data,
    output logic                           afu_c0Rx_rspValid,
    output logic                           afu_c0Rx_mmioRdValid,
    output logic                           afu_c0Rx_mmioWrValid,
    output logic [CCIP_C1RX_HDR_WIDTH-1:0] afu_c1Rx_hdr,
    output logic                           afu_c1Rx_rspValid,
    input  logic [CCIP_C0TX_HDR_WIDTH-1:0] afu_c0Tx_hdr,
    input  logic                           afu_c0Tx_valid,
    input  logic [CCIP_C1TX_HDR_WIDTH-1:0] afu_c1Tx_hdr,
    input  logic [CCIP_CLDATA_WIDTH-1:0]   afu_c1Tx_data,
    input  logic                           afu_c1Tx_valid,
    input  logic [CCIP_C2TX_HDR_WIDTH-1:0] afu_c2Tx_hdr,
    input  logic                           afu_c2Tx_mmioRdValid,
    input  logic [CCIP_MMIODATA_WIDTH-1:0] afu_c2Tx_data,
    output logic                           afu_c0TxAlmFull,
    output logic                           afu_c1TxAlmFull,
    output logic [CCIP_C0TX_HDR_WIDTH-1:0] c0Tx_hdr,
    output logic                           c0Tx_valid,
    output logic [CCIP_C1TX_HDR_WIDTH-1:0] c1Tx_hdr,
    output logic [CCIP_CLDATA_WIDTH-1:0]   c1Tx_data,
    output logic                           c1Tx_valid,
    output logic [CCIP_C2TX_HDR_WIDTH-1:0] c2Tx_hdr,
    output logic                           c2Tx_mmioRdValid,
    output logic [CCIP_MMIODATA_WIDTH-1:0] c2Tx_data,
    output logic [$clog2(TX_DEPTH):0]      c0_level,
    output logic [$clog2(TX_DEPTH):0]      c1_level,
    output logic                           c0_ovf,
    output logic                           c1_ovf
);
    localparam int unsigned AW    = $clog2(TX_DEPTH);
    localparam int unsigned AfInt = TX_DEPTH - AF_SLACK;
    localparam int unsigned C1EW  = CCIP_C1TX_HDR_WIDTH + CCIP_CLDATA_WIDTH;
    localparam logic [AW:0]   LvlFull = TX_DEPTH[AW:0];
    localparam logic [AW:0]   LvlAf   = AfInt[AW:0];
    localparam logic [AW:0]   LvlOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    // ---------------- Rx delay pipeline ----------------
    if (RX_STAGES == 0) begin : g_rx_bypass
        assign afu_c0Rx_hdr         = c0Rx_hdr;
        assign afu_c0Rx_data        = c0Rx_data;
        assign afu_c0Rx_rspValid    = c0Rx_rspValid;
        assign afu_c0Rx_mmioRdValid = c0Rx_mmioRdValid;
        assign afu_c0Rx_mmioWrValid = c0Rx_mmioWrValid;
        assign afu_c1Rx_hdr         = c1Rx_hdr;
        assign afu_c1Rx_rspValid    = c1Rx_rspValid;
    end else begin : g_rx_pipe
        logic [CCIP_C0RX_HDR_WIDTH-1:0] r_c0_hdr  [RX_STAGES];
        logic [CCIP_CLDATA_WIDTH-1:0]   r_c0_data [RX_STAGES];
        logic [CCIP_C1RX_HDR_WIDTH-1:0] r_c1_hdr  [RX_STAGES];
        logic [RX_STAGES-1:0] r_c0_rsp, r_c0_rd, r_c0_wr, r_c1_rsp;

        always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
            if (!pck_cp2af_softReset_n) begin
                r_c0_rsp <= '0;
                r_c0_rd  <= '0;
                r_c0_wr  <= '0;
                r_c1_rsp <= '0;
            end else begin
                r_c0_rsp[0] <= c0Rx_rspValid;
                r_c0_rd[0]  <= c0Rx_mmioRdValid;
                r_c0_wr[0]  <= c0Rx_mmioWrValid;
                r_c1_rsp[0] <= c1Rx_rspValid;
                for (int i = 1; i < RX_STAGES; i++) begin
                    r_c0_rsp[i] <= r_c0_rsp[i-1];
                    r_c0_rd[i]  <= r_c0_rd[i-1];
                    r_c0_wr[i]  <= r_c0_wr[i-1];
                    r_c1_rsp[i] <= r_c1_rsp[i-1];
                end
            end
        end

        always_ff @(posedge pClk) begin
            r_c0_hdr[0]  <= c0Rx_hdr;
            r_c0_data[0] <= c0Rx_data;
            r_c1_hdr[0]  <= c1Rx_hdr;
            for (int i = 1; i < RX_STAGES; i++) begin
                r_c0_hdr[i]  <= r_c0_hdr[i-1];
                r_c0_data[i] <= r_c0_data[i-1];
                r_c1_hdr[i]  <= r_c1_hdr[i-1];
            end
        end

        assign afu_c0Rx_hdr         = r_c0_hdr[RX_STAGES-1];
        assign afu_c0Rx_data        = r_c0_data[RX_STAGES-1];
        assign afu_c0Rx_rspValid    = r_c0_rsp[RX_STAGES-1];
        assign afu_c0Rx_mmioRdValid = r_c0_rd[RX_STAGES-1];
        assign afu_c0Rx_mmioWrValid = r_c0_wr[RX_STAGES-1];
        assign afu_c1Rx_hdr         = r_c1_hdr[RX_STAGES-1];
        assign afu_c1Rx_rspValid    = r_c1_rsp[RX_STAGES-1];
    end

    // ---------------- Tx c0 FIFO ----------------
    logic [CCIP_C0TX_HDR_WIDTH-1:0] r_c0_mem [TX_DEPTH];
    logic [CCIP_C0TX_HDR_WIDTH-1:0] r_c0tx_hdr;
    logic [AW-1:0] r_c0_wp, r_c0_rp;
    logic [AW:0]   r_c0_lvl;
    logic          r_c0_ovf, r_c0tx_valid;
    logic          w_c0_pop, w_c0_push;

    assign w_c0_pop  = (r_c0_lvl != '0) && !c0TxAlmFull;
    // A full FIFO still accepts when an entry leaves on the same edge.
    assign w_c0_push = afu_c0Tx_valid && ((r_c0_lvl != LvlFull) || w_c0_pop);

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_c0_wp      <= '0;
            r_c0_rp      <= '0;
            r_c0_lvl     <= '0;
            r_c0_ovf     <= 1'b0;
            r_c0tx_valid <= 1'b0;
        end else begin
            if (w_c0_push) r_c0_wp <= r_c0_wp + PtrOne;
            if (w_c0_pop)  r_c0_rp <= r_c0_rp + PtrOne;
            if (w_c0_push && !w_c0_pop)      r_c0_lvl <= r_c0_lvl + LvlOne;
            else if (!w_c0_push && w_c0_pop) r_c0_lvl <= r_c0_lvl - LvlOne;
            if (afu_c0Tx_valid && !w_c0_push) r_c0_ovf <= 1'b1;
            r_c0tx_valid <= w_c0_pop;
        end
    end

    always_ff @(posedge pClk) begin
        if (w_c0_push) r_c0_mem[r_c0_wp] <= afu_c0Tx_hdr;
        if (w_c0_pop)  r_c0tx_hdr <= r_c0_mem[r_c0_rp];
    end

    // ---------------- Tx c1 FIFO (hdr+data per entry) ----------------
    logic [C1EW-1:0] r_c1_mem [TX_DEPTH];
    logic [C1EW-1:0] r_c1tx_ent;
    logic [AW-1:0]   r_c1_wp, r_c1_rp;
    logic [AW:0]     r_c1_lvl;
    logic            r_c1_ovf, r_c1tx_valid;
    logic            w_c1_pop, w_c1_push;

    assign w_c1_pop  = (r_c1_lvl != '0) && !c1TxAlmFull;
    assign w_c1_push = afu_c1Tx_valid && ((r_c1_lvl != LvlFull) || w_c1_pop);

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_c1_wp      <= '0;
            r_c1_rp      <= '0;
            r_c1_lvl     <= '0;
            r_c1_ovf     <= 1'b0;
            r_c1tx_valid <= 1'b0;
        end else begin
            if (w_c1_push) r_c1_wp <= r_c1_wp + PtrOne;
            if (w_c1_pop)  r_c1_rp <= r_c1_rp + PtrOne;
            if (w_c1_push && !w_c1_pop)      r_c1_lvl <= r_c1_lvl + LvlOne;
            else if (!w_c1_push && w_c1_pop) r_c1_lvl <= r_c1_lvl - LvlOne;
            if (afu_c1Tx_valid && !w_c1_push) r_c1_ovf <= 1'b1;
            r_c1tx_valid <= w_c1_pop;
        end
    end

    always_ff @(posedge pClk) begin
        if (w_c1_push) r_c1_mem[r_c1_wp] <= {afu_c1Tx_hdr, afu_c1Tx_data};
        if (w_c1_pop)  r_c1tx_ent <= r_c1_mem[r_c1_rp];
    end

    // ---------------- Tx c2 register ----------------
    logic [CCIP_C2TX_HDR_WIDTH-1:0] r_c2_hdr;
    logic [CCIP_MMIODATA_WIDTH-1:0] r_c2_data;
    logic                           r_c2_valid;

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) r_c2_valid <= 1'b0;
        else                        r_c2_valid <= afu_c2Tx_mmioRdValid;
    end

    always_ff @(posedge pClk) begin
        r_c2_hdr  <= afu_c2Tx_hdr;
        r_c2_data <= afu_c2Tx_data;
    end

    assign c0Tx_hdr             = r_c0tx_hdr;
    assign c0Tx_valid           = r_c0tx_valid;
    assign {c1Tx_hdr, c1Tx_data} = r_c1tx_ent;
    assign c1Tx_valid           = r_c1tx_valid;
    assign c2Tx_hdr             = r_c2_hdr;
    assign c2Tx_data            = r_c2_data;
    assign c2Tx_mmioRdValid     = r_c2_valid;
    assign c0_level             = r_c0_lvl;
    assign c1_level             = r_c1_lvl;
    assign c0_ovf               = r_c0_ovf;
    assign c1_ovf               = r_c1_ovf;
    assign afu_c0TxAlmFull      = (r_c0_lvl >= LvlAf);
    assign afu_c1TxAlmFull      = (r_c1_lvl >= LvlAf);

endmodule

// File: tb/tb_ccip_shim_buffer.sv
// Randomized + directed bench for ccip_shim_buffer against a queue-based reference model.
module tb_ccip_shim_buffer;
    localparam int unsigned D    = 8;
    localparam int unsigned AF   = 4;
    localparam int unsigned HW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned C2HW = 8;
    localparam int unsigned MW   = 32;

    logic pClk = 1'b0;
    logic rst_n = 1'b0;
    always #5 pClk = ~pClk;

    logic c0TxAlmFull, c1TxAlmFull;
    logic [HW-1:0] c0Rx_hdr, c1Rx_hdr, afu_c0Rx_hdr, afu_c1Rx_hdr;
    logic [DW-1:0] c0Rx_data, afu_c0Rx_data;
    logic c0Rx_rspValid, c0Rx_mmioRdValid, c0Rx_mmioWrValid, c1Rx_rspValid;
    logic afu_c0Rx_rspValid, afu_c0Rx_mmioRdValid, afu_c0Rx_mmioWrValid, afu_c1Rx_rspValid;
    logic [HW-1:0] afu_c0Tx_hdr, afu_c1Tx_hdr, c0Tx_hdr, c1Tx_hdr;
    logic [DW-1:0] afu_c1Tx_data, c1Tx_data;
    logic afu_c0Tx_valid, afu_c1Tx_valid, c0Tx_valid, c1Tx_valid;
    logic [C2HW-1:0] afu_c2Tx_hdr, c2Tx_hdr;
    logic [MW-1:0] afu_c2Tx_data, c2Tx_data;
    logic afu_c2Tx_mmioRdValid, c2Tx_mmioRdValid;
    logic afu_c0TxAlmFull, afu_c1TxAlmFull, c0_ovf, c1_ovf;
    logic [$clog2(D):0] c0_level, c1_level;

    ccip_shim_buffer #(
        .RX_STAGES(2), .TX_DEPTH(D), .AF_SLACK(AF),
        .CCIP_C0RX_HDR_WIDTH(HW), .CCIP_C1RX_HDR_WIDTH(HW), .CCIP_CLDATA_WIDTH(DW),
        .CCIP_C0TX_HDR_WIDTH(HW), .CCIP_C1TX_HDR_WIDTH(HW), .CCIP_C2TX_HDR_WIDTH(C2HW),
        .CCIP_MMIODATA_WIDTH(MW)
    ) u_dut (
        .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
        .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
        .c0Rx_hdr(c0Rx_hdr), .c0Rx_data(c0Rx_data), .c0Rx_rspValid(c0Rx_rspValid),
        .c0Rx_mmioRdValid(c0Rx_mmioRdValid), .c0Rx_mmioWrValid(c0Rx_mmioWrValid),
        .c1Rx_hdr(c1Rx_hdr), .c1Rx_rspValid(c1Rx_rspValid),
        .afu_c0Rx_hdr(afu_c0Rx_hdr), .afu_c0Rx_data(afu_c0Rx_data),
        .afu_c0Rx_rspValid(afu_c0Rx_rspValid), .afu_c0Rx_mmioRdValid(afu_c0Rx_mmioRdValid),
        .afu_c0Rx_mmioWrValid(afu_c0Rx_mmioWrValid), .afu_c1Rx_hdr(afu_c1Rx_hdr),
        .afu_c1Rx_rspValid(afu_c1Rx_rspValid),
        .afu_c0Tx_hdr(afu_c0Tx_hdr), .afu_c0Tx_valid(afu_c0Tx_valid),
        .afu_c1Tx_hdr(afu_c1Tx_hdr), .afu_c1Tx_data(afu_c1Tx_data),
        .afu_c1Tx_valid(afu_c1Tx_valid),
        .afu_c2Tx_hdr(afu_c2Tx_hdr), .afu_c2Tx_mmioRdValid(afu_c2Tx_mmioRdValid),
        .afu_c2Tx_data(afu_c2Tx_data),
        .afu_c0TxAlmFull(afu_c0TxAlmFull), .afu_c1TxAlmFull(afu_c1TxAlmFull),
        .c0Tx_hdr(c0Tx_hdr), .c0Tx_valid(c0Tx_valid),
        .c1Tx_hdr(c1Tx_hdr), .c1Tx_data(c1Tx_data), .c1Tx_valid(c1Tx_valid),
        .c2Tx_hdr(c2Tx_hdr), .c2Tx_mmioRdValid(c2Tx_mmioRdValid), .c2Tx_data(c2Tx_data),
        .c0_level(c0_level), .c1_level(c1_level), .c0_ovf(c0_ovf), .c1_ovf(c1_ovf)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [HW-1:0] hdr0;
        logic [DW-1:0] data0;
        logic          rsp0, rd0, wr0;
        logic [HW-1:0] hdr1;
        logic          rsp1;
    } rx_t;

    rx_t               rxq[$];
    logic [HW-1:0]     q0[$];
    logic [HW+DW-1:0]  q1[$];
    logic [HW-1:0]     m_c0_hdr;
    logic [HW+DW-1:0]  m_c1_ent;
    logic [C2HW-1:0]   m_c2_hdr;
    logic [MW-1:0]     m_c2_data;
    logic m_c0_vld = 1'b0, m_c1_vld = 1'b0, m_c2_vld = 1'b0;
    logic m_ovf0 = 1'b0, m_ovf1 = 1'b0;
    bit   k0 = 0, k1 = 0, k2 = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_async_reset();
        q0.delete();
        q1.delete();
        m_c0_vld = 1'b0;
        m_c1_vld = 1'b0;
        m_c2_vld = 1'b0;
        m_ovf0   = 1'b0;
        m_ovf1   = 1'b0;
        foreach (rxq[i]) begin
            rxq[i].rsp0 = 1'b0; rxq[i].rd0 = 1'b0; rxq[i].wr0 = 1'b0; rxq[i].rsp1 = 1'b0;
        end
    endtask

    task automatic model_edge();
        rx_t s;
        bit  pop;
        s = '{hdr0: c0Rx_hdr, data0: c0Rx_data, rsp0: c0Rx_rspValid, rd0: c0Rx_mmioRdValid,
              wr0: c0Rx_mmioWrValid, hdr1: c1Rx_hdr, rsp1: c1Rx_rspValid};
        if (!rst_n) begin
            s.rsp0 = 1'b0; s.rd0 = 1'b0; s.wr0 = 1'b0; s.rsp1 = 1'b0;
        end
        rxq.push_back(s);
        if (rxq.size() > 2) void'(rxq.pop_front());
        m_c2_hdr  = afu_c2Tx_hdr;
        m_c2_data = afu_c2Tx_data;
        k2        = 1;
        if (!rst_n) begin
            model_async_reset();
            return;
        end
        m_c2_vld = afu_c2Tx_mmioRdValid;
        // Pop leaves first, so a full queue with a pop has room for this edge's push.
        pop = (q0.size() > 0) && !c0TxAlmFull;
        m_c0_vld = pop;
        if (pop) begin m_c0_hdr = q0.pop_front(); k0 = 1; end
        if (afu_c0Tx_valid) begin
            if (q0.size() < D) q0.push_back(afu_c0Tx_hdr);
            else m_ovf0 = 1'b1;
        end
        pop = (q1.size() > 0) && !c1TxAlmFull;
        m_c1_vld = pop;
        if (pop) begin m_c1_ent = q1.pop_front(); k1 = 1; end
        if (afu_c1Tx_valid) begin
            if (q1.size() < D) q1.push_back({afu_c1Tx_hdr, afu_c1Tx_data});
            else m_ovf1 = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("c0_valid", c0Tx_valid, m_c0_vld);
        if (k0) chk("c0_hdr", c0Tx_hdr, m_c0_hdr);
        chk("c0_level", c0_level, q0.size());
        chk("c0_almfull", afu_c0TxAlmFull, q0.size() >= D - AF);
        chk("c0_ovf", c0_ovf, m_ovf0);
        chk("c1_valid", c1Tx_valid, m_c1_vld);
        if (k1) chk("c1_entry", {c1Tx_hdr, c1Tx_data}, m_c1_ent);
        chk("c1_level", c1_level, q1.size());
        chk("c1_almfull", afu_c1TxAlmFull, q1.size() >= D - AF);
        chk("c1_ovf", c1_ovf, m_ovf1);
        chk("c2_valid", c2Tx_mmioRdValid, m_c2_vld);
        if (k2) chk("c2_fields", {c2Tx_hdr, c2Tx_data}, {m_c2_hdr, m_c2_data});
        if (rxq.size() == 2) begin
            chk("rx_c0_fields", {afu_c0Rx_hdr, afu_c0Rx_data}, {rxq[0].hdr0, rxq[0].data0});
            chk("rx_c0_valids", {afu_c0Rx_rspValid, afu_c0Rx_mmioRdValid, afu_c0Rx_mmioWrValid},
                {rxq[0].rsp0, rxq[0].rd0, rxq[0].wr0});
            chk("rx_c1", {afu_c1Rx_hdr, afu_c1Rx_rspValid}, {rxq[0].hdr1, rxq[0].rsp1});
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        afu_c0Tx_valid = 1'b0; afu_c1Tx_valid = 1'b0; afu_c2Tx_mmioRdValid = 1'b0;
        c0Rx_rspValid = 1'b0; c0Rx_mmioRdValid = 1'b0; c0Rx_mmioWrValid = 1'b0;
        c1Rx_rspValid = 1'b0;
        c0TxAlmFull = 1'b0; c1TxAlmFull = 1'b0;
    endtask

    task automatic rand_rx();
        c0Rx_hdr = HW'($urandom); c0Rx_data = $urandom; c1Rx_hdr = HW'($urandom);
        c0Rx_rspValid = $urandom_range(0, 1) == 1; c0Rx_mmioRdValid = $urandom_range(0, 1) == 1;
        c0Rx_mmioWrValid = $urandom_range(0, 1) == 1; c1Rx_rspValid = $urandom_range(0, 1) == 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_async_reset();
        #1;
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_levels", {c0_level, c1_level}, '0);
        chk("rel_almfull", {afu_c0TxAlmFull, afu_c1TxAlmFull}, 2'b00);
    endtask

    initial begin
        int n;
        logic [HW+DW-1:0] sent[$];
        idle_inputs();
        c0Rx_hdr = '0; c0Rx_data = '0; c1Rx_hdr = '0;
        afu_c0Tx_hdr = '0; afu_c1Tx_hdr = '0; afu_c1Tx_data = '0;
        afu_c2Tx_hdr = '0; afu_c2Tx_data = '0;
        tick();
        tick();
        chk("rst_valids", {c0Tx_valid, c1Tx_valid, c2Tx_mmioRdValid}, 3'b000);
        chk("rst_ovf", {c0_ovf, c1_ovf}, 2'b00);
        rst_n = 1'b1;
        #1;
        chk("rst_levels", {c0_level, c1_level}, '0);
        tick();
        tick();

        // Rx: single pulse appears exactly two cycles later
        c0Rx_rspValid = 1'b1; c0Rx_hdr = 16'hA5C3;
        tick();
        chk("rx_pulse_t1", afu_c0Rx_rspValid, 1'b0);
        c0Rx_rspValid = 1'b0; c0Rx_hdr = 16'h0000;
        tick();
        chk("rx_pulse_t2", {afu_c0Rx_rspValid, afu_c0Rx_hdr}, {1'b1, 16'hA5C3});
        tick();
        chk("rx_pulse_t3", afu_c0Rx_rspValid, 1'b0);

        // Fill c0 under platform back-pressure, then overflow
        c0TxAlmFull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            afu_c0Tx_valid = 1'b1; afu_c0Tx_hdr = HW'(16'h100 + i); tick();
        end
        chk("fill4_level", c0_level, 4);
        chk("fill4_almfull", afu_c0TxAlmFull, 1'b1);
        for (int i = 4; i < 8; i++) begin
            afu_c0Tx_hdr = HW'(16'h100 + i); tick();
        end
        chk("fill8_level", c0_level, 8);
        chk("fill8_ovf", c0_ovf, 1'b0);
        afu_c0Tx_hdr = 16'h01FF;
        tick();
        chk("ovf_level", c0_level, 8);
        chk("ovf_flag", c0_ovf, 1'b1);
        afu_c0Tx_valid = 1'b0;

        // Release: eight pulses in push order
        c0TxAlmFull = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (c0Tx_valid) begin
                chk("drain_hdr", c0Tx_hdr, 16'h100 + n);
                n++;
            end
        end
        chk("drain_count", n, 8);

        // Full FIFO with simultaneous push and pop
        do_reset();
        c0TxAlmFull = 1'b1;
        for (int i = 0; i < 8; i++) begin
            afu_c0Tx_valid = 1'b1; afu_c0Tx_hdr = HW'(16'h200 + i); tick();
        end
        c0TxAlmFull = 1'b0; afu_c0Tx_hdr = 16'h02AA;
        tick();
        chk("pushpop_level", c0_level, 8);
        chk("pushpop_ovf", c0_ovf, 1'b0);
        afu_c0Tx_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (c0Tx_valid) n++;
        end
        chk("pushpop_last", c0Tx_hdr, 16'h02AA);
        chk("pushpop_count", n, 8);

        // c1 continuous push with AlmFull toggling every cycle
        sent.delete();
        for (int i = 0; i < 12; i++) begin
            afu_c1Tx_valid = 1'b1; afu_c1Tx_hdr = HW'($urandom); afu_c1Tx_data = $urandom;
            sent.push_back({afu_c1Tx_hdr, afu_c1Tx_data});
            c1TxAlmFull = i[0];
            tick();
            if (c1Tx_valid) chk("toggle_data", {c1Tx_hdr, c1Tx_data}, sent.pop_front());
        end
        afu_c1Tx_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            c1TxAlmFull = i[0];
            tick();
            if (c1Tx_valid) begin
                if (sent.size() == 0) chk("toggle_extra", 1'b1, 1'b0);
                else chk("toggle_data", {c1Tx_hdr, c1Tx_data}, sent.pop_front());
            end
        end
        chk("toggle_remaining", sent.size(), 0);
        chk("toggle_ovf", c1_ovf, 1'b0);

        // Random traffic on all channels
        for (int i = 0; i < 400; i++) begin
            rand_rx();
            afu_c0Tx_valid = $urandom_range(0, 2) != 0; afu_c0Tx_hdr = HW'($urandom);
            afu_c1Tx_valid = $urandom_range(0, 2) != 0; afu_c1Tx_hdr = HW'($urandom);
            afu_c1Tx_data = $urandom;
            c0TxAlmFull = $urandom_range(0, 9) < 3; c1TxAlmFull = $urandom_range(0, 9) < 3;
            afu_c2Tx_mmioRdValid = $urandom_range(0, 1) == 1;
            afu_c2Tx_hdr = C2HW'($urandom); afu_c2Tx_data = $urandom;
            tick();
        end

        // Mid-stream reset with c1 at level 5 and outputs active
        idle_inputs();
        do_reset();
        c1TxAlmFull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            afu_c1Tx_valid = 1'b1; afu_c1Tx_hdr = HW'(16'h300 + i); afu_c1Tx_data = $urandom;
            afu_c0Tx_valid = 1'b1; afu_c0Tx_hdr = HW'(16'h400 + i);
            afu_c2Tx_mmioRdValid = 1'b1;
            c0Rx_rspValid = 1'b1; c1Rx_rspValid = 1'b1;
            tick();
        end
        chk("mid_c1_level", c1_level, 5);
        chk("mid_c0_active", c0Tx_valid, 1'b1);
        rst_n = 1'b0;
        model_async_reset();
        #1;
        chk("mid_rst_valids", {c0Tx_valid, c1Tx_valid, c2Tx_mmioRdValid, afu_c0Rx_rspValid,
            afu_c1Rx_rspValid}, 5'b00000);
        chk("mid_rst_level", c1_level, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_level", c1_level, 0);
        chk("mid_rel_almfull", afu_c1TxAlmFull, 1'b0);
        afu_c1Tx_valid = 1'b1; afu_c1Tx_hdr = 16'h0BEE; afu_c1Tx_data = 32'hCAFE_F00D;
        tick();
        afu_c1Tx_valid = 1'b0;
        chk("mid_push_t1", c1Tx_valid, 1'b0);
        tick();
        chk("mid_push_t2", {c1Tx_valid, c1Tx_hdr, c1Tx_data}, {1'b1, 16'h0BEE, 32'hCAFE_F00D});
        tick();
        chk("mid_push_t3", c1Tx_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccip_shim_buffer.md
CCIP_SHIM_BUFFER -- requirements
Module: ccip_shim_buffer

Interface
REQ-001 SHALL have parameter RX_STAGES, default 1, which sets the Rx pipeline register stages (0..4).
REQ-002 SHALL have parameter TX_DEPTH, default 8, which sets the entries per Tx FIFO (power of 2, >=4).
REQ-003 SHALL have parameter AF_SLACK, default 4, which sets the free entries reserved when AFU almost-full asserts (1..TX_DEPTH-1).
REQ-004 pClk  in  1  sole clock, all state on rising edge.
REQ-005 pck_cp2af_softReset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 c0TxAlmFull / c1TxAlmFull  in  1 each  platform back-pressure per Tx channel.
REQ-007 c0Rx_hdr, c0Rx_data, c0Rx_rspValid, c0Rx_mmioRdValid, c0Rx_mmioWrValid  in  CCIP_C0RX_HDR_WIDTH / CCIP_CLDATA_WIDTH / 1 / 1 / 1  platform Rx channel 0.
REQ-008 c1Rx_hdr, c1Rx_rspValid  in  CCIP_C1RX_HDR_WIDTH / 1  platform Rx channel 1.
REQ-009 afu_c0Rx_*, afu_c1Rx_*  out  same widths as REQ-007/008  Rx fields delayed to AFU.
REQ-010 afu_c0Tx_hdr, afu_c0Tx_valid  in  CCIP_C0TX_HDR_WIDTH / 1  AFU read request.
REQ-011 afu_c1Tx_hdr, afu_c1Tx_data, afu_c1Tx_valid  in  CCIP_C1TX_HDR_WIDTH / CCIP_CLDATA_WIDTH / 1  AFU write request.
REQ-012 afu_c2Tx_hdr, afu_c2Tx_mmioRdValid, afu_c2Tx_data  in  CCIP_C2TX_HDR_WIDTH / 1 / CCIP_MMIODATA_WIDTH  AFU MMIO read response.
REQ-013 afu_c0TxAlmFull / afu_c1TxAlmFull  out  1 each  back-pressure to AFU.
REQ-014 c0Tx_hdr, c0Tx_valid; c1Tx_hdr, c1Tx_data, c1Tx_valid; c2Tx_hdr, c2Tx_mmioRdValid, c2Tx_data  out  platform widths  platform Tx channels.
REQ-015 c0_level / c1_level  out  $clog2(TX_DEPTH)+1 each  current FIFO occupancy.
REQ-016 c0_ovf / c1_ovf  out  1 each  sticky overflow flags.

Function
REQ-017 Rx: every field SHALL be delayed by exactly RX_STAGES cycles with all fields aligned; RX_STAGES=0 SHALL be a combinational pass-through.
REQ-018 Tx c0/c1 SHALL each have an independent TX_DEPTH FIFO; c1 entries SHALL store hdr+data.
REQ-019 Push: afu_cNTx_valid=1 and (level<TX_DEPTH or same-cycle pop) SHALL write one entry.
REQ-020 Pop: level>0 and cNTxAlmFull=0 (sampled same edge) SHALL load the entry into the cNTx output register, giving cNTx_valid=1 for exactly one cycle.
REQ-021 No pop SHALL set cNTx_valid=0; hdr/data SHALL hold their last values.
REQ-022 Latency from push edge into empty FIFO to cNTx_valid=1 SHALL be 2 cycles with AlmFull low; throughput SHALL be 1 entry/cycle.
REQ-023 Order SHALL be FIFO within each channel, with no ordering between c0 and c1.
REQ-024 level SHALL update +1 on push only, -1 on pop only, unchanged on both; pointers SHALL wrap modulo TX_DEPTH.
REQ-025 afu_cNTxAlmFull SHALL equal (level >= TX_DEPTH-AF_SLACK), decoded from the level register.
REQ-026 Push while full with no pop SHALL drop the request, leave the FIFO unchanged, and set cN_ovf=1 until reset.
REQ-027 c2 SHALL be one register stage: c2Tx_* = afu_c2Tx_* delayed 1 cycle, with no buffering or back-pressure.
REQ-028 AlmFull toggling SHALL never lose or duplicate an entry.

Reset
REQ-029 Reset low SHALL asynchronously clear: FIFO pointers, levels, cN_ovf, c0Tx_valid, c1Tx_valid, c2Tx_mmioRdValid, and all Rx-stage valid bits (rspValid/mmioRdValid/mmioWrValid).
REQ-030 hdr/data registers and FIFO storage SHALL NOT need reset.
REQ-031 Reset mid-operation SHALL discard buffered entries; the first cycle after deassertion SHALL show level=0 and afu_cNTxAlmFull=0.

Verification
REQ-032 RX_STAGES=2: c0Rx_rspValid pulse with hdr=H at cycle t -> afu_c0Rx_rspValid=1 and hdr=H at t+2 only.
REQ-033 TX_DEPTH=8, AF_SLACK=4, c0TxAlmFull=1: push 4 -> afu_c0TxAlmFull=1 and c0_level=4; push 4 more -> level=8, c0_ovf=0; 9th push -> dropped, c0_ovf=1, level=8.
REQ-034 Release c0TxAlmFull after REQ-033 -> 8 consecutive c0Tx_valid pulses, hdrs in push order.
REQ-035 Full FIFO, AlmFull=0, push+pop same cycle -> level stays 8, no ovf, new entry emerges last.
REQ-036 Continuous c1 push with c1TxAlmFull toggling 1-on/1-off -> all data out in order, none lost or duplicated.
REQ-037 Reset asserted with level=5 mid-stream -> all valids 0 immediately; after release, one push gives c1Tx_valid two cycles later.
